// File: rtl/dp4_pkg.sv
// Shared constants for the DP4 feeder: pipe latency, operand width,
// precision encodings and handy floating-point constants.
package dp4_pkg;

  localparam int DP4_LAT = 5;
  localparam int DP4_W   = 32;

  typedef enum logic {
    MODE_FP16 = 1'b0,
    MODE_FP32 = 1'b1
  } dp4_mode_e;

  localparam logic [31:0] ONE_FP32 = 32'h3F80_0000;
  localparam logic [15:0] ONE_FP16 = 16'h3C00;

endpackage

// File: rtl/dp4_result_fifo.sv
// Synchronous result FIFO holding {tag, data}; pointers carry a wrap bit so
// full/empty/count fall out of a pointer compare. DEPTH must be a power of two.
module dp4_result_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 33,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/dp4_feeder.sv
// Packs element pairs into four-lane DP4 issues, tracks in-flight results with a
// latency-matched shift register and buffers them under credit flow control.
module dp4_feeder
  import dp4_pkg::*;
#(
  parameter int LAT        = DP4_LAT,
  parameter int FIFO_DEPTH = 4,
  parameter int W          = DP4_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mode_req,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  input  logic         in_last,
  output logic         dp_mode,
  output logic [W-1:0] dp_a,
  output logic [W-1:0] dp_b,
  output logic [W-1:0] dp_c,
  output logic [W-1:0] dp_d,
  output logic [W-1:0] dp_e,
  output logic [W-1:0] dp_f,
  output logic [W-1:0] dp_g,
  output logic [W-1:0] dp_h,
  input  logic [W-1:0] dp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_fp16,
  output logic         busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]       lane_q, lane_d;
  logic             dp_mode_q, dp_mode_d;
  logic [LAT:0]     sr_valid_q, sr_valid_d;
  logic [LAT:0]     sr_tag_q, sr_tag_d;
  logic [W-1:0]     x_ext, y_ext;
  logic [7:0]       inflight;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  logic [W:0]       fifo_head;
  logic             completing, credit_ok, mode_pending;
  logic             accept, issue, mode_apply, pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= LAT; i++) inflight = inflight + 8'(sr_valid_q[i]);
  end

  assign x_ext = (dp_mode_q == MODE_FP16) ? {{(W-16){1'b0}}, in_x[15:0]} : in_x;
  assign y_ext = (dp_mode_q == MODE_FP16) ? {{(W-16){1'b0}}, in_y[15:0]} : in_y;

  // A pending mode change still lets the open group finish in the old mode;
  // new groups wait until the pipe has drained and dp_mode has switched.
  assign completing   = (lane_q == 2'd3) | in_last;
  assign credit_ok    = !fifo_full && ((inflight + 8'(fifo_count)) < 8'(FIFO_DEPTH));
  assign mode_pending = (mode_req != dp_mode_q);
  assign in_ready     = reset & (!mode_pending | (lane_q != '0)) & (!completing | credit_ok);
  assign accept       = in_valid & in_ready;
  assign issue        = accept & completing;
  assign mode_apply   = mode_pending & (lane_q == '0) & (inflight == '0);

  always_comb begin
    lane_d = lane_q;
    if (accept) lane_d = completing ? 2'd0 : lane_q + 2'd1;
    dp_mode_d  = mode_apply ? mode_req : dp_mode_q;
    sr_valid_d = {sr_valid_q[LAT-1:0], issue};
    sr_tag_d   = {sr_tag_q[LAT-1:0], dp_mode_q == MODE_FP16};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lane_q     <= '0;
      dp_mode_q  <= MODE_FP32;
      sr_valid_q <= '0;
      sr_tag_q   <= '0;
    end else begin
      lane_q     <= lane_d;
      dp_mode_q  <= dp_mode_d;
      sr_valid_q <= sr_valid_d;
      sr_tag_q   <= sr_tag_d;
    end
  end

  // Each lane holds its staged pair; the issue register drives for one cycle only.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [W-1:0] x_q, y_q, dx_q, dy_q;

    always_ff @(posedge clk) begin
      if (!reset) begin
        x_q  <= '0;
        y_q  <= '0;
        dx_q <= '0;
        dy_q <= '0;
      end else begin
        if (accept && lane_q == 2'(gi)) begin
          x_q <= x_ext;
          y_q <= y_ext;
        end
        if (issue && lane_q == 2'(gi)) begin
          dx_q <= x_ext;
          dy_q <= y_ext;
        end else if (issue && lane_q > 2'(gi)) begin
          dx_q <= x_q;
          dy_q <= y_q;
        end else begin
          dx_q <= '0;
          dy_q <= '0;
        end
      end
    end
  end

  assign dp_mode = dp_mode_q;
  assign dp_a = g_lane[0].dx_q;
  assign dp_b = g_lane[0].dy_q;
  assign dp_c = g_lane[1].dx_q;
  assign dp_d = g_lane[1].dy_q;
  assign dp_e = g_lane[2].dx_q;
  assign dp_f = g_lane[2].dy_q;
  assign dp_g = g_lane[3].dx_q;
  assign dp_h = g_lane[3].dy_q;

  dp4_result_fifo #(
    .DEPTH(FIFO_DEPTH),
    .DW   (W + 1)
  ) u_fifo (
    .clk        (clk),
    .rst_n_i    (reset),
    .push_i     (sr_valid_q[LAT]),
    .push_data_i({sr_tag_q[LAT], dp_result}),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid & out_ready;
  assign out_fp16  = out_valid & fifo_head[W];
  assign out_data  = !out_valid ? '0 :
                     fifo_head[W] ? {{(W-16){1'b0}}, fifo_head[15:0]} : fifo_head[W-1:0];
  assign busy      = (lane_q != '0) | (inflight != '0) | !fifo_empty;

endmodule
